// File: rtl/ipc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ipc_pkg
// Purpose  : Shared inter-processor-communication types and constants.
// Revision : 1.0 - initial release
// ============================================================================
package ipc_pkg;

   // Top-level states of the IPI transmit scheduler.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DELIVER = 2'd1,
      DONE    = 2'd2
   } ipi_sched_state_e;

endpackage : ipc_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. The search starts at the
//            position just above the one-hot last_grant and wraps around.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] last_grant,
   output logic [N-1:0] grant
);

   logic [N-1:0] upper_mask;
   logic [N-1:0] masked_req;
   logic [N-1:0] pick_src;
   logic         seen;

   // Requests above the last winner take priority; otherwise wrap to bit 0.
   always_comb begin
      seen = 1'b0;
      for (int j = 0; j < N; j++) begin
         upper_mask[j] = seen;
         seen          = seen | last_grant[j];
      end
      masked_req = req & upper_mask;
      pick_src   = (|masked_req) ? masked_req : req;
      grant      = pick_src & (-pick_src);
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/ipi_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ipi_tx_scheduler
// Purpose  : Picks one sender core round-robin and delivers its word to each
//            target RX FIFO in its mask, lowest target first, then pulses
//            done_valid back to the sender.
// Options  : IPI_SCHED_TIMEOUT_EN - skip a target that stalls for
//            TIMEOUT_CYCLES cycles and report it in done_drop.
// Revision : 1.0 - initial release
// ============================================================================
module ipi_tx_scheduler
   import ipc_pkg::*;
#(
   parameter int CORES          = 4,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CORES-1:0]          tx_valid,
   output logic [CORES-1:0]          tx_ready,
   input  logic [CORES*CORES-1:0]    tx_mask,
   input  logic [CORES*DATA_W-1:0]   tx_data,
   output logic [CORES-1:0]          push_valid,
   input  logic [CORES-1:0]          push_ready,
   output logic [DATA_W-1:0]         push_data,
   output logic [CORES-1:0]          done_valid,
   output logic [CORES-1:0]          done_drop,
   output logic                      busy
);

   localparam logic [CORES-1:0] LAST_GRANT_RST = {1'b1, {(CORES-1){1'b0}}};

   ipi_sched_state_e   state_q,      state_d;
   logic [CORES-1:0]   last_grant_q, last_grant_d;
   logic [CORES-1:0]   pending_q,    pending_d;
   logic [CORES-1:0]   sender_q,     sender_d;
   logic [DATA_W-1:0]  data_q,       data_d;

   logic [CORES-1:0]   rr_grant;
   logic [CORES-1:0]   req_mask;
   logic [DATA_W-1:0]  req_data;
   logic [CORES-1:0]   target;

`ifdef IPI_SCHED_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CORES-1:0]   drop_q,    drop_d;
   logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic               timeout_hit;
`else
   logic               unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

   rr_arbiter #(
      .N (CORES)
   ) u_rr_arbiter (
      .req        (tx_valid),
      .last_grant (last_grant_q),
      .grant      (rr_grant)
   );

   // Mux the winning sender's mask and word out of the flattened buses.
   always_comb begin
      req_mask = '0;
      req_data = '0;
      for (int s = 0; s < CORES; s++) begin
         if (rr_grant[s]) begin
            req_mask = req_mask | tx_mask[s*CORES +: CORES];
            req_data = req_data | tx_data[s*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state and output logic of the scheduler FSM.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      pending_d    = pending_q;
      sender_d     = sender_q;
      data_d       = data_q;
      tx_ready     = '0;
      push_valid   = '0;
      done_valid   = '0;
      done_drop    = '0;
      push_data    = data_q;
      busy         = (state_q != IDLE);
      target       = pending_q & (-pending_q);
`ifdef IPI_SCHED_TIMEOUT_EN
      drop_d       = drop_q;
      tmo_cnt_d    = tmo_cnt_q;
      timeout_hit  = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));
`endif

      case (state_q)
         IDLE: begin
            if (|tx_valid) begin
               // Grant is masked while reset is held so tx_ready reads 0.
               tx_ready     = rr_grant & {CORES{rst_n}};
               last_grant_d = rr_grant;
               sender_d     = rr_grant;
               pending_d    = req_mask;
               data_d       = req_data;
`ifdef IPI_SCHED_TIMEOUT_EN
               drop_d       = '0;
               tmo_cnt_d    = '0;
`endif
               state_d      = (req_mask == '0) ? DONE : DELIVER;
            end
         end

         DELIVER: begin
`ifdef IPI_SCHED_TIMEOUT_EN
            if (timeout_hit) begin
               // Give up on the stalled target; no push this cycle.
               pending_d = pending_q & ~target;
               drop_d    = drop_q | target;
               tmo_cnt_d = '0;
            end else begin
               push_valid = target;
               if (|(target & push_ready)) begin
                  pending_d = pending_q & ~target;
                  tmo_cnt_d = '0;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
               end
            end
`else
            push_valid = target;
            if (|(target & push_ready)) begin
               pending_d = pending_q & ~target;
            end
`endif
            if (pending_d == '0) begin
               state_d = DONE;
            end
         end

         DONE: begin
            done_valid = sender_q;
`ifdef IPI_SCHED_TIMEOUT_EN
            done_drop  = drop_q;
`endif
            state_d    = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Scheduler state; reset discards any in-flight message.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= LAST_GRANT_RST;
         pending_q    <= '0;
         sender_q     <= '0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         pending_q    <= pending_d;
         sender_q     <= sender_d;
         data_q       <= data_d;
      end
   end

`ifdef IPI_SCHED_TIMEOUT_EN
   // Stall counter and accumulated drop mask for the timeout option.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q    <= '0;
         tmo_cnt_q <= '0;
      end else begin
         drop_q    <= drop_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`endif

endmodule : ipi_tx_scheduler
`default_nettype wire

// File: tb/tb_ipi_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ipi_tx_scheduler
// Purpose  : Directed self-checking bench for ipi_tx_scheduler
//            (CORES=4, DATA_W=32, TIMEOUT_CYCLES=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ipi_tx_scheduler;

   localparam int CORES  = 4;
   localparam int DATA_W = 32;
   localparam int TMO    = 8;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [CORES-1:0]         tx_valid;
   logic [CORES-1:0]         tx_ready;
   logic [CORES*CORES-1:0]   tx_mask;
   logic [CORES*DATA_W-1:0]  tx_data;
   logic [CORES-1:0]         push_valid;
   logic [CORES-1:0]         push_ready;
   logic [DATA_W-1:0]        push_data;
   logic [CORES-1:0]         done_valid;
   logic [CORES-1:0]         done_drop;
   logic                     busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0] exp_order [4];
   logic [3:0] winner;
   int         wait_cnt;

   ipi_tx_scheduler #(
      .CORES          (CORES),
      .DATA_W         (DATA_W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_mask    (tx_mask),
      .tx_data    (tx_data),
      .push_valid (push_valid),
      .push_ready (push_ready),
      .push_data  (push_data),
      .done_valid (done_valid),
      .done_drop  (done_drop),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      exp_order[0] = 4'b0001;
      exp_order[1] = 4'b0100;
      exp_order[2] = 4'b1000;
      exp_order[3] = 4'b0001;

      // Reset with every input active: all outputs must read 0.
      rst_n      = 1'b1;
      tx_valid   = 4'hF;
      tx_mask    = 16'hFFFF;
      tx_data    = {4{32'hA5A5A5A5}};
      push_ready = 4'hF;
      #2 rst_n = 1'b0;
      #1;
      check("rst_tx_ready",   32'(tx_ready),   32'h0);
      check("rst_push_valid", 32'(push_valid), 32'h0);
      check("rst_push_data",  push_data,       32'h0);
      check("rst_done_valid", 32'(done_valid), 32'h0);
      check("rst_done_drop",  32'(done_drop),  32'h0);
      check("rst_busy",       32'(busy),       32'h0);
      repeat (3) @(posedge clk);
      #1;
      rst_n    = 1'b1;
      tx_valid = 4'h0;
      tx_mask  = '0;
      tx_data  = '0;

      // Sender 1, mask 1010, all ready: targets 1 then 3, done at grant+3.
      tx_mask[7:4]   = 4'b1010;
      tx_data[63:32] = 32'hDEADBEEF;
      tx_valid       = 4'b0010;
      #1;
      check("a_grant",    32'(tx_ready), 32'h2);
      check("a_idle",     32'(busy),     32'h0);
      tick();
      tx_valid = 4'b0000;
      #1;
      check("a_push1",    32'(push_valid), 32'h2);
      check("a_data1",    push_data,       32'hDEADBEEF);
      check("a_noready",  32'(tx_ready),   32'h0);
      check("a_busy",     32'(busy),       32'h1);
      tick(); #1;
      check("a_push2",    32'(push_valid), 32'h8);
      check("a_data2",    push_data,       32'hDEADBEEF);
      check("a_nodone",   32'(done_valid), 32'h0);
      tick(); #1;
      check("a_done",     32'(done_valid), 32'h2);
      check("a_drop",     32'(done_drop),  32'h0);
      check("a_nopush",   32'(push_valid), 32'h0);
      tick(); #1;
      check("a_back_idle", 32'(busy),       32'h0);
      check("a_done_once", 32'(done_valid), 32'h0);

      // Fresh reset, senders 0/2/3 request; 0 keeps re-requesting.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tx_mask         = '0;
      tx_mask[3:0]    = 4'b0001;
      tx_mask[11:8]   = 4'b0001;
      tx_mask[15:12]  = 4'b0001;
      tx_valid        = 4'b1101;
      #1;
      for (int i = 0; i < 4; i++) begin
         wait_cnt = 0;
         while (tx_ready == 4'b0000 && wait_cnt < 20) begin
            tick(); #1;
            wait_cnt++;
         end
         check("rr_grant", 32'(tx_ready), 32'(exp_order[i]));
         winner = tx_ready;
         tick();
         if (i == 3) tx_valid = 4'b0000;
         else        tx_valid = tx_valid & ~(winner & 4'b1110);
         #1;
      end
      repeat (2) tick();
      #1;
      check("rr_drained", 32'(busy), 32'h0);

      // Sender 2 with an empty mask: straight to DONE, no push.
      tx_mask[11:8] = 4'b0000;
      tx_valid      = 4'b0100;
      #1;
      check("z_grant", 32'(tx_ready), 32'h4);
      tick();
      tx_valid = 4'b0000;
      #1;
      check("z_done",   32'(done_valid), 32'h4);
      check("z_nopush", 32'(push_valid), 32'h0);
      tick(); #1;
      check("z_idle",   32'(busy), 32'h0);

      // Sender 3, mask 0011, target 0 stalls 5 cycles.
      tx_mask[15:12]   = 4'b0011;
      tx_data[127:96]  = 32'h12345678;
      push_ready       = 4'b1110;
      tx_valid         = 4'b1000;
      #1;
      check("s_grant", 32'(tx_ready), 32'h8);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 0) tx_valid = 4'b0000;
         if (i == 5) push_ready = 4'hF;
         #1;
         check("s_hold_t0", 32'(push_valid), 32'h1);
         check("s_hold_dt", push_data,       32'h12345678);
      end
      tick(); #1;
      check("s_push_t1", 32'(push_valid), 32'h2);
      check("s_data_t1", push_data,       32'h12345678);
      tick(); #1;
      check("s_done",    32'(done_valid), 32'h8);
      check("s_drop",    32'(done_drop),  32'h0);
      tick(); #1;
      check("s_idle",    32'(busy), 32'h0);

`ifdef IPI_SCHED_TIMEOUT_EN
      // Sender 0, mask 0101, target 0 never ready: dropped after 8 stalls.
      tx_mask[3:0]   = 4'b0101;
      tx_data[31:0]  = 32'hCAFEF00D;
      push_ready     = 4'b1110;
      tx_valid       = 4'b0001;
      #1;
      check("t_grant", 32'(tx_ready), 32'h1);
      for (int i = 0; i < 8; i++) begin
         tick();
         tx_valid = 4'b0000;
         #1;
         check("t_stall", 32'(push_valid), 32'h1);
      end
      tick(); #1;
      check("t_skip_cycle", 32'(push_valid), 32'h0);
      check("t_skip_busy",  32'(busy),       32'h1);
      tick(); #1;
      check("t_push_t2",    32'(push_valid), 32'h4);
      check("t_data_t2",    push_data,       32'hCAFEF00D);
      tick(); #1;
      check("t_done",       32'(done_valid), 32'h1);
      check("t_drop",       32'(done_drop),  32'h1);
      tick(); #1;
      check("t_idle",       32'(busy), 32'h0);
      push_ready = 4'hF;
`endif

      // Reset in the middle of DELIVER.
      tx_mask[7:4] = 4'b1111;
      push_ready   = 4'b0000;
      tx_valid     = 4'b0010;
      #1;
      check("r_grant", 32'(tx_ready), 32'h2);
      tick();
      tx_valid = 4'b0000;
      #1;
      check("r_busy",    32'(busy),       32'h1);
      check("r_pushing", 32'(push_valid), 32'h1);
      #2;
      rst_n    = 1'b0;
      tx_valid = 4'b1011;
      #1;
      check("r_tx_ready",   32'(tx_ready),   32'h0);
      check("r_push_valid", 32'(push_valid), 32'h0);
      check("r_push_data",  push_data,       32'h0);
      check("r_busy_low",   32'(busy),       32'h0);
      check("r_done_valid", 32'(done_valid), 32'h0);
      check("r_done_drop",  32'(done_drop),  32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check("r_post_busy",  32'(busy),     32'h0);
      check("r_post_grant", 32'(tx_ready), 32'h1);
      tick();
      tx_valid   = 4'b0000;
      push_ready = 4'hF;
      repeat (8) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_ipi_tx_scheduler
`default_nettype wire
